alu_pipe: RTL and testbench
===========================

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning the datapath and address width.
REQ-002 The block SHALL have parameter ROB_W, default 4, meaning the reorder-tag width.
REQ-003 The block SHALL have parameter OQ_DEPTH, default 2 (power of two, at least 2), meaning the result-queue depth.
REQ-004 The block SHALL have port clk_in, input, 1 bit: the single clock.
REQ-005 The block SHALL have port rst_in, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port rdy_in, input, 1 bit: global run enable; low freezes the block.
REQ-007 The block SHALL have port clear_in, input, 1 bit: misprediction flush.
REQ-008 The block SHALL have ports alu_s, input, 1 bit, and alu_rdy, output, 1 bit: the issue handshake with the RS.
REQ-009 The block SHALL have port op, input, 6 bits: shared opcode encoding.
REQ-010 The block SHALL have ports vj, vk, a and pc, input, XLEN bits each: operands, immediate and instruction PC.
REQ-011 The block SHALL have port reorder, input, ROB_W bits: destination ROB tag.
REQ-012 The block SHALL have ports cdb_s, output, 1 bit, and cdb_grant, input, 1 bit: the CDB request and arbiter grant.
REQ-013 The block SHALL have ports cdb_reorder (ROB_W), cdb_value (XLEN), cdb_jump_s (1) and cdb_jump (XLEN), all outputs: the broadcast result.

Function
REQ-014 An issue SHALL occur when alu_s, alu_rdy and rdy_in are all high and clear_in is low.
REQ-015 An issued operation SHALL be computed combinationally and written to the queue tail at that clock edge, so it is visible on the CDB outputs the next cycle (latency 1).
REQ-016 alu_rdy SHALL equal (count < OQ_DEPTH) and rdy_in and not clear_in; a same-cycle pop SHALL NOT free a full queue for issue.
REQ-017 cdb_s SHALL be high exactly when count > 0, and the cdb_* outputs SHALL show the queue head.
REQ-018 A pop SHALL occur when cdb_s, cdb_grant and rdy_in are high; the head SHALL stay stable until granted.
REQ-019 Simultaneous push and pop SHALL leave count unchanged, and the pointers SHALL wrap modulo OQ_DEPTH.
REQ-020 The queue state SHALL be one of EMPTY (count 0), PARTIAL or FULL (count OQ_DEPTH), and transitions SHALL change count by at most 1 per cycle.
REQ-021 clear_in high SHALL, at the edge, empty the queue and drop any same-cycle issue; clear_in SHALL take priority over push and pop.
REQ-022 rdy_in low SHALL freeze all state; the outputs SHALL hold their values.
REQ-023 Arithmetic SHALL be modulo 2^XLEN.
REQ-024 Shift amounts SHALL use the low log2(XLEN) bits.
REQ-025 SLT, SLTI and the signed branches SHALL compare signed; SLTU, SLTIU, BLTU and BGEU SHALL compare unsigned.
REQ-026 JAL and JALR SHALL give value pc+4. The JAL target SHALL be pc+a; the JALR target SHALL be (vj+a) with bit 0 cleared.
REQ-027 Taken branches SHALL set cdb_jump_s=1 and cdb_jump=pc+a; not-taken branches SHALL give value 0 and jump_s 0.
REQ-028 Unknown opcodes SHALL broadcast value 0 and jump_s 0 with their tag.

Reset
REQ-029 rst_in SHALL asynchronously set count and the pointers to 0.
REQ-030 During and after reset, cdb_s SHALL be 0, all other cdb_* outputs 0, and alu_rdy 0 while rst_in is high.
REQ-031 Reset mid-operation SHALL discard all queued results.

Configuration
REQ-032 With ALU_MUL_EN defined, opcodes MUL, MULH, MULHSU and MULHU SHALL be executed with latency 1: the low or high XLEN bits of the 2*XLEN product, with signedness per RV32M.
REQ-033 Without ALU_MUL_EN, those opcodes SHALL be treated as unknown and no multiplier SHALL be instantiated.

Structure
REQ-034 A shared package alu_pkg SHALL hold the opcode localparams (the 6-bit encodings including the MUL codes) and the queue-entry struct {reorder, value, jump_s, jump}.
REQ-035 A combinational sub-module alu_core SHALL compute the queue entry from op, vj, vk, a and pc; alu_pipe SHALL hold the queue and handshakes.

Verification
REQ-036 ADDI vj=5, a=-3, tag 2 -> the next cycle cdb_s=1, value 2, reorder 2, jump_s 0.
REQ-037 SLTU vj=0xFFFFFFFF, vk=1 -> value 0; SLT with the same operands -> value 1; SRA vj=0x80000000, vk=33 -> 0xC0000000.
REQ-038 cdb_grant held low and three back-to-back issues -> two accepted, alu_rdy low; grant one cycle -> head pops in order and alu_rdy rises the following cycle.
REQ-039 JALR pc=0x100, vj=0x203, a=4 -> value 0x104, jump_s 1, jump 0x206; BNE with vj=vk -> jump_s 0.
REQ-040 Queue holding two results, clear_in pulsed while alu_s is high -> next cycle cdb_s=0 and count 0; rst_in asserted mid-pop -> immediately cdb_s=0.
REQ-041 With ALU_MUL_EN, MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; without ALU_MUL_EN -> value 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue pipe: opcode encodings and the
// result-queue entry. Entry fields are sized for the widest supported
// configuration (XLEN <= 64, ROB_W <= 8); narrower builds zero-extend into them.
package alu_pkg;

  localparam int XLEN_MAX  = 64;
  localparam int ROB_W_MAX = 8;

  // 6-bit opcode encodings (0 is reserved / unknown)
  localparam logic [5:0] OP_ADD    = 6'd1;
  localparam logic [5:0] OP_SUB    = 6'd2;
  localparam logic [5:0] OP_SLL    = 6'd3;
  localparam logic [5:0] OP_SLT    = 6'd4;
  localparam logic [5:0] OP_SLTU   = 6'd5;
  localparam logic [5:0] OP_XOR    = 6'd6;
  localparam logic [5:0] OP_SRL    = 6'd7;
  localparam logic [5:0] OP_SRA    = 6'd8;
  localparam logic [5:0] OP_OR     = 6'd9;
  localparam logic [5:0] OP_AND    = 6'd10;
  localparam logic [5:0] OP_ADDI   = 6'd11;
  localparam logic [5:0] OP_SLTI   = 6'd12;
  localparam logic [5:0] OP_SLTIU  = 6'd13;
  localparam logic [5:0] OP_XORI   = 6'd14;
  localparam logic [5:0] OP_ORI    = 6'd15;
  localparam logic [5:0] OP_ANDI   = 6'd16;
  localparam logic [5:0] OP_SLLI   = 6'd17;
  localparam logic [5:0] OP_SRLI   = 6'd18;
  localparam logic [5:0] OP_SRAI   = 6'd19;
  localparam logic [5:0] OP_LUI    = 6'd20;
  localparam logic [5:0] OP_AUIPC  = 6'd21;
  localparam logic [5:0] OP_JAL    = 6'd22;
  localparam logic [5:0] OP_JALR   = 6'd23;
  localparam logic [5:0] OP_BEQ    = 6'd24;
  localparam logic [5:0] OP_BNE    = 6'd25;
  localparam logic [5:0] OP_BLT    = 6'd26;
  localparam logic [5:0] OP_BGE    = 6'd27;
  localparam logic [5:0] OP_BLTU   = 6'd28;
  localparam logic [5:0] OP_BGEU   = 6'd29;
  localparam logic [5:0] OP_MUL    = 6'd32;
  localparam logic [5:0] OP_MULH   = 6'd33;
  localparam logic [5:0] OP_MULHSU = 6'd34;
  localparam logic [5:0] OP_MULHU  = 6'd35;

  typedef struct packed {
    logic [ROB_W_MAX-1:0] reorder;
    logic [XLEN_MAX-1:0]  value;
    logic                 jump_s;
    logic [XLEN_MAX-1:0]  jump;
  } alu_entry_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: turns one issued operation into a queue entry.
// Optional multiply support is compiled in with ALU_MUL_EN; without it the
// MUL opcodes fall through to the unknown-opcode result.
module alu_core
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [5:0]      op,
  input  logic [XLEN-1:0] vj,
  input  logic [XLEN-1:0] vk,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] pc,
  output alu_entry_t      ent
);

  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0] val;
  logic [XLEN-1:0] tgt;
  logic            js;
  logic [SHW-1:0]  sh_k;
  logic [SHW-1:0]  sh_a;
  logic            lt_s, lt_u, lt_si, lt_ui;

  assign sh_k  = vk[SHW-1:0];
  assign sh_a  = a[SHW-1:0];
  assign lt_s  = $signed(vj) < $signed(vk);
  assign lt_u  = vj < vk;
  assign lt_si = $signed(vj) < $signed(a);
  assign lt_ui = vj < a;

`ifdef ALU_MUL_EN
  // Operands are sign/zero-extended to 2*XLEN so one unsigned multiply per
  // signedness mix yields the exact product in its low 2*XLEN bits.
  logic [2*XLEN-1:0] prod_uu, prod_ss, prod_su;
  assign prod_uu = {{XLEN{1'b0}}, vj} * {{XLEN{1'b0}}, vk};
  assign prod_ss = {{XLEN{vj[XLEN-1]}}, vj} * {{XLEN{vk[XLEN-1]}}, vk};
  assign prod_su = {{XLEN{vj[XLEN-1]}}, vj} * {{XLEN{1'b0}}, vk};
`endif

  // Opcode decode and result select
  always_comb begin
    val = '0;
    tgt = '0;
    js  = 1'b0;
    case (op)
      OP_ADD:   val = vj + vk;
      OP_SUB:   val = vj - vk;
      OP_SLL:   val = vj << sh_k;
      OP_SLT:   val = XLEN'(lt_s);
      OP_SLTU:  val = XLEN'(lt_u);
      OP_XOR:   val = vj ^ vk;
      OP_SRL:   val = vj >> sh_k;
      OP_SRA:   val = $unsigned($signed(vj) >>> sh_k);
      OP_OR:    val = vj | vk;
      OP_AND:   val = vj & vk;
      OP_ADDI:  val = vj + a;
      OP_SLTI:  val = XLEN'(lt_si);
      OP_SLTIU: val = XLEN'(lt_ui);
      OP_XORI:  val = vj ^ a;
      OP_ORI:   val = vj | a;
      OP_ANDI:  val = vj & a;
      OP_SLLI:  val = vj << sh_a;
      OP_SRLI:  val = vj >> sh_a;
      OP_SRAI:  val = $unsigned($signed(vj) >>> sh_a);
      OP_LUI:   val = a;
      OP_AUIPC: val = pc + a;
      OP_JAL: begin
        val = pc + XLEN'(4);
        tgt = pc + a;
        js  = 1'b1;
      end
      OP_JALR: begin
        val    = pc + XLEN'(4);
        tgt    = vj + a;
        tgt[0] = 1'b0;
        js     = 1'b1;
      end
      // Branches: value stays 0; target only driven when taken
      OP_BEQ:  js = (vj == vk);
      OP_BNE:  js = (vj != vk);
      OP_BLT:  js = lt_s;
      OP_BGE:  js = !lt_s;
      OP_BLTU: js = lt_u;
      OP_BGEU: js = !lt_u;
`ifdef ALU_MUL_EN
      OP_MUL:    val = prod_uu[XLEN-1:0];
      OP_MULH:   val = prod_ss[2*XLEN-1:XLEN];
      OP_MULHSU: val = prod_su[2*XLEN-1:XLEN];
      OP_MULHU:  val = prod_uu[2*XLEN-1:XLEN];
`endif
      default: begin
        val = '0;
        js  = 1'b0;
      end
    endcase
    if (js && (op >= OP_BEQ) && (op <= OP_BGEU)) tgt = pc + a;
  end

  // Tag is attached by the queue owner
  always_comb begin
    ent         = '0;
    ent.value   = XLEN_MAX'(val);
    ent.jump_s  = js;
    ent.jump    = XLEN_MAX'(tgt);
  end

endmodule

// File: rtl/alu_pipe.sv
// ALU issue pipe: accepts operations from the RS, computes them in one cycle
// and holds results in a small queue until the CDB arbiter grants broadcast.
// Build option: define ALU_MUL_EN to enable MUL/MULH/MULHSU/MULHU.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ROB_W    = 4,
  parameter int OQ_DEPTH = 2
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             clear_in,
  input  logic             alu_s,
  output logic             alu_rdy,
  input  logic [5:0]       op,
  input  logic [XLEN-1:0]  vj,
  input  logic [XLEN-1:0]  vk,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  pc,
  input  logic [ROB_W-1:0] reorder,
  output logic             cdb_s,
  input  logic             cdb_grant,
  output logic [ROB_W-1:0] cdb_reorder,
  output logic [XLEN-1:0]  cdb_value,
  output logic             cdb_jump_s,
  output logic [XLEN-1:0]  cdb_jump
);

  localparam int PW = (OQ_DEPTH > 1) ? $clog2(OQ_DEPTH) : 1;
  localparam logic [PW:0] DEPTH_C = (PW+1)'(OQ_DEPTH);

  // Queue occupancy states, derived from count
  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_PARTIAL = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;

  alu_entry_t    q [OQ_DEPTH];
  alu_entry_t    core_e;
  alu_entry_t    new_e;
  alu_entry_t    head_e;
  logic [PW-1:0] head_ptr, tail_ptr;
  logic [PW:0]   count;
  logic [1:0]    q_state;
  logic          push, pop;
  logic          unused_head;

  alu_core #(.XLEN(XLEN)) u_core (
    .op  (op),
    .vj  (vj),
    .vk  (vk),
    .a   (a),
    .pc  (pc),
    .ent (core_e)
  );

  // Attach destination tag to the computed result
  always_comb begin
    new_e         = core_e;
    new_e.reorder = ROB_W_MAX'(reorder);
  end

  // Classify occupancy
  always_comb begin
    if (count == '0)          q_state = ST_EMPTY;
    else if (count == DEPTH_C) q_state = ST_FULL;
    else                      q_state = ST_PARTIAL;
  end

  // Readiness uses registered fullness, so a same-cycle pop never admits an issue
  assign alu_rdy = (q_state != ST_FULL) && rdy_in && !clear_in && !rst_in;
  assign push    = alu_s && alu_rdy;
  assign pop     = cdb_s && cdb_grant && rdy_in && !clear_in;

  assign head_e      = q[head_ptr];
  assign unused_head = ^head_e;

  // Outputs forced to zero whenever nothing valid is at the head
  assign cdb_s       = (q_state != ST_EMPTY);
  assign cdb_reorder = cdb_s ? head_e.reorder[ROB_W-1:0] : '0;
  assign cdb_value   = cdb_s ? head_e.value[XLEN-1:0]    : '0;
  assign cdb_jump_s  = cdb_s ? head_e.jump_s             : 1'b0;
  assign cdb_jump    = cdb_s ? head_e.jump[XLEN-1:0]     : '0;

  // Pointer and count bookkeeping; flush beats push/pop, rdy_in low freezes
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (rdy_in) begin
      if (clear_in) begin
        head_ptr <= '0;
        tail_ptr <= '0;
        count    <= '0;
      end else begin
        if (push) tail_ptr <= tail_ptr + 1'b1;
        if (pop)  head_ptr <= head_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Result storage; contents are only meaningful below count, so no reset
  always_ff @(posedge clk_in) begin
    if (push) q[tail_ptr] <= new_e;
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe.
module tb_alu_pipe;
  import alu_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear_in, alu_s, alu_rdy, cdb_s, cdb_grant, cdb_jump_s;
  logic [5:0]  op;
  logic [31:0] vj, vk, a, pc, cdb_value, cdb_jump;
  logic [3:0]  reorder, cdb_reorder;

  int checks = 0;
  int failures = 0;

  alu_pipe #(.XLEN(32), .ROB_W(4), .OQ_DEPTH(2)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .alu_s(alu_s), .alu_rdy(alu_rdy), .op(op), .vj(vj), .vk(vk), .a(a), .pc(pc),
    .reorder(reorder), .cdb_s(cdb_s), .cdb_grant(cdb_grant),
    .cdb_reorder(cdb_reorder), .cdb_value(cdb_value),
    .cdb_jump_s(cdb_jump_s), .cdb_jump(cdb_jump)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [5:0] o, input logic [31:0] j, input logic [31:0] k,
                       input logic [31:0] im, input logic [31:0] p, input logic [3:0] tag);
    alu_s = 1'b1; op = o; vj = j; vk = k; a = im; pc = p; reorder = tag;
  endtask

  task automatic tick();
    @(posedge clk_in); #1;
  endtask

  // Single op through an empty queue with grant held high
  task automatic run_op(input string nm, input logic [5:0] o, input logic [31:0] j,
                        input logic [31:0] k, input logic [31:0] im, input logic [31:0] p,
                        input logic [3:0] tag, input logic [31:0] ev, input logic ejs,
                        input logic [31:0] ejmp);
    cdb_grant = 1'b1;
    drive(o, j, k, im, p, tag);
    tick();
    alu_s = 1'b0;
    chk({nm, ".cdb_s"}, 64'(cdb_s), 64'd1);
    chk({nm, ".value"}, 64'(cdb_value), 64'(ev));
    chk({nm, ".tag"}, 64'(cdb_reorder), 64'(tag));
    chk({nm, ".jump_s"}, 64'(cdb_jump_s), 64'(ejs));
    chk({nm, ".jump"}, 64'(cdb_jump), 64'(ejmp));
    tick();
    chk({nm, ".popped"}, 64'(cdb_s), 64'd0);
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; clear_in = 1'b0; alu_s = 1'b0; cdb_grant = 1'b0;
    op = '0; vj = '0; vk = '0; a = '0; pc = '0; reorder = '0;
    #3;
    chk("rst.alu_rdy", 64'(alu_rdy), 64'd0);
    chk("rst.cdb_s", 64'(cdb_s), 64'd0);
    chk("rst.value", 64'(cdb_value), 64'd0);
    tick();
    rst_in = 1'b0;
    #1;
    chk("post_rst.alu_rdy", 64'(alu_rdy), 64'd1);
    chk("post_rst.cdb_s", 64'(cdb_s), 64'd0);
    chk("post_rst.jump", 64'(cdb_jump), 64'd0);
    tick();

    // Directed ALU vectors
    run_op("addi",  OP_ADDI, 32'd5, 32'd0, 32'hFFFF_FFFD, 32'd0, 4'd2, 32'd2, 1'b0, 32'd0);
    run_op("sltu",  OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 4'd3, 32'd0, 1'b0, 32'd0);
    run_op("slt",   OP_SLT,  32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 4'd4, 32'd1, 1'b0, 32'd0);
    run_op("sra",   OP_SRA,  32'h8000_0000, 32'd33, 32'd0, 32'd0, 4'd5, 32'hC000_0000, 1'b0, 32'd0);
    run_op("sll",   OP_SLL,  32'd3, 32'h21, 32'd0, 32'd0, 4'd6, 32'd6, 1'b0, 32'd0);
    run_op("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 4'd7, 32'd1, 1'b0, 32'd0);
    run_op("jalr",  OP_JALR, 32'h203, 32'd0, 32'd4, 32'h100, 4'd8, 32'h104, 1'b1, 32'h206);
    run_op("jal",   OP_JAL,  32'd0, 32'd0, 32'h20, 32'h200, 4'd9, 32'h204, 1'b1, 32'h220);
    run_op("bne_nt", OP_BNE, 32'd7, 32'd7, 32'h10, 32'h40, 4'd10, 32'd0, 1'b0, 32'd0);
    run_op("bltu_t", OP_BLTU, 32'd1, 32'hFFFF_FFFF, 32'h10, 32'h40, 4'd11, 32'd0, 1'b1, 32'h50);
    run_op("blt_nt", OP_BLT, 32'd1, 32'hFFFF_FFFF, 32'h10, 32'h40, 4'd12, 32'd0, 1'b0, 32'd0);
    run_op("unknown", 6'h3F, 32'd9, 32'd9, 32'd9, 32'd9, 4'd5, 32'd0, 1'b0, 32'd0);
`ifdef ALU_MUL_EN
    run_op("mulhu", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 4'd1, 32'hFFFF_FFFE, 1'b0, 32'd0);
`else
    run_op("mulhu", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 4'd1, 32'd0, 1'b0, 32'd0);
`endif

    // Backpressure: grant low, three back-to-back issues
    cdb_grant = 1'b0;
    drive(OP_ADDI, 32'd10, 32'd0, 32'd0, 32'd0, 4'd1); tick();
    drive(OP_ADDI, 32'd20, 32'd0, 32'd0, 32'd0, 4'd2); tick();
    chk("bp.full_rdy", 64'(alu_rdy), 64'd0);
    drive(OP_ADDI, 32'd30, 32'd0, 32'd0, 32'd0, 4'd3); tick();
    chk("bp.head_tag", 64'(cdb_reorder), 64'd1);
    chk("bp.head_val", 64'(cdb_value), 64'd10);
    chk("bp.still_full", 64'(alu_rdy), 64'd0);
    cdb_grant = 1'b1; tick();
    chk("bp.pop1_tag", 64'(cdb_reorder), 64'd2);
    chk("bp.pop1_val", 64'(cdb_value), 64'd20);
    chk("bp.rdy_rise", 64'(alu_rdy), 64'd1);
    tick();
    chk("bp.pushpop_tag", 64'(cdb_reorder), 64'd3);
    chk("bp.pushpop_val", 64'(cdb_value), 64'd30);
    alu_s = 1'b0; tick();
    chk("bp.drained", 64'(cdb_s), 64'd0);

    // Flush with two queued results and a concurrent issue
    cdb_grant = 1'b0;
    drive(OP_ADDI, 32'd40, 32'd0, 32'd0, 32'd0, 4'd4); tick();
    drive(OP_ADDI, 32'd50, 32'd0, 32'd0, 32'd0, 4'd5); tick();
    drive(OP_ADDI, 32'd60, 32'd0, 32'd0, 32'd0, 4'd6);
    clear_in = 1'b1; #1;
    chk("clr.alu_rdy", 64'(alu_rdy), 64'd0);
    tick();
    clear_in = 1'b0; alu_s = 1'b0; #1;
    chk("clr.cdb_s", 64'(cdb_s), 64'd0);
    chk("clr.alu_rdy_back", 64'(alu_rdy), 64'd1);
    chk("clr.tag", 64'(cdb_reorder), 64'd0);
    tick();
    run_op("after_clr", OP_XOR, 32'hF0F0, 32'h0FF0, 32'd0, 32'd0, 4'd13, 32'hFF00, 1'b0, 32'd0);

    // Freeze: rdy_in low holds state even with grant and issue pending
    cdb_grant = 1'b0;
    drive(OP_ADDI, 32'd77, 32'd0, 32'd0, 32'd0, 4'd7); tick();
    rdy_in = 1'b0; cdb_grant = 1'b1;
    drive(OP_ADDI, 32'd88, 32'd0, 32'd0, 32'd0, 4'd8);
    tick();
    chk("frz.cdb_s", 64'(cdb_s), 64'd1);
    chk("frz.val", 64'(cdb_value), 64'd77);
    chk("frz.alu_rdy", 64'(alu_rdy), 64'd0);
    tick();
    chk("frz.val2", 64'(cdb_value), 64'd77);
    rdy_in = 1'b1; alu_s = 1'b0; tick();
    chk("frz.popped", 64'(cdb_s), 64'd0);

    // Reset asserted while a pop is pending
    cdb_grant = 1'b0;
    drive(OP_ADDI, 32'd1, 32'd0, 32'd0, 32'd0, 4'd9); tick();
    drive(OP_ADDI, 32'd2, 32'd0, 32'd0, 32'd0, 4'd10); tick();
    alu_s = 1'b0; cdb_grant = 1'b1;
    chk("rstmid.pre", 64'(cdb_s), 64'd1);
    rst_in = 1'b1; #1;
    chk("rstmid.cdb_s", 64'(cdb_s), 64'd0);
    chk("rstmid.value", 64'(cdb_value), 64'd0);
    chk("rstmid.alu_rdy", 64'(alu_rdy), 64'd0);
    tick();
    rst_in = 1'b0; tick();
    chk("rstmid.after", 64'(cdb_s), 64'd0);
    chk("rstmid.rdy", 64'(alu_rdy), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
